// File: rtl/snake_body_scheduler.sv
// Snake body scheduler: scans the segment RAM during horizontal blanking
// and drives a per-block body enable for the next block row.
module snake_body_scheduler #(
    parameter int H_ACTIVE   = 640,
    parameter int H_TOTAL    = 800,
    parameter int V_ACTIVE   = 480,
    parameter int V_TOTAL    = 525,
    parameter int PIX_W      = 10,
    parameter int COORD_W    = 7,
    parameter int ROW_BLOCKS = 80,
    parameter int STARVE     = 16
) (
    input  logic               clock_25,
    input  logic               reset,
    input  logic [PIX_W-1:0]   X,
    input  logic [PIX_W-1:0]   Y,
    input  logic [3:0]         snake_length,
    output logic               seg_rd,
    output logic [3:0]         seg_addr,
    input  logic [COORD_W-1:0] seg_x,
    input  logic [COORD_W-1:0] seg_y,
    input  logic               game_req,
    output logic               game_gnt,
    output logic               en_snake_body,
    output logic               scan_busy,
    output logic               scan_overrun
);

    localparam int SW = $clog2(STARVE + 1);
    localparam logic [PIX_W-1:0] XA = PIX_W'(H_ACTIVE);
    localparam logic [PIX_W-1:0] XE = PIX_W'(H_TOTAL - 1);
    localparam logic [PIX_W-1:0] YA = PIX_W'(V_ACTIVE);
    localparam logic [PIX_W-1:0] YL = PIX_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] RB = COORD_W'(ROW_BLOCKS);
    localparam logic [SW-1:0] SLIM = SW'(STARVE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_READ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ROW_BLOCKS-1:0] shadow_q, shadow_d;
    logic [ROW_BLOCKS-1:0] active_q, active_d;
    logic [3:0]            idx_q, idx_d;
    logic [3:0]            len_q, len_d;
    logic [COORD_W-1:0]    row_q, row_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  en_q, en_d;
    logic                  ovr_q, ovr_d;

    logic             eol;
    logic             yield;
    logic [PIX_W-1:0] nl;

    assign eol       = (X == XE);
    assign yield     = game_req && (starve_q < SLIM);
    assign scan_busy = (state_q == S_CLEAR) || (state_q == S_READ) ||
                       (state_q == S_WAIT);
    assign seg_rd    = (state_q == S_READ) && !yield;
    assign seg_addr  = idx_q;
    assign game_gnt  = game_req && !seg_rd;

    assign en_snake_body = en_q;
    assign scan_overrun  = ovr_q;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        idx_d    = idx_q;
        len_d    = len_q;
        row_d    = row_q;
        starve_d = starve_q;
        ovr_d    = ovr_q;
        nl       = (Y == YL) ? '0 : Y + PIX_W'(1);
        unique case (state_q)
            S_IDLE: begin
                if (X == XA && nl < YA && nl[2:0] == 3'd0) begin
                    row_d   = COORD_W'(nl >> 3);
                    len_d   = snake_length;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                shadow_d = '0;
                idx_d    = '0;
                state_d  = (len_q == 4'd0) ? S_DONE : S_READ;
            end
            S_READ: begin
                if (yield) begin
                    starve_d = starve_q + SW'(1);
                end else begin
                    starve_d = '0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (seg_y == row_q && seg_x < RB)
                    shadow_d[seg_x] = 1'b1;
                idx_d = idx_q + 4'd1;
                if ({1'b0, idx_q} + 5'd1 == {1'b0, len_q})
                    state_d = S_DONE;
                else
                    state_d = S_READ;
            end
            S_DONE: begin
                if (eol) begin
                    active_d = shadow_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A late scan must never expose a partial mask: blank the row.
        if (scan_busy && eol) begin
            state_d  = S_IDLE;
            active_d = '0;
            starve_d = '0;
            ovr_d    = 1'b1;
        end
        en_d = (X < XA && Y < YA) ? active_q[X[PIX_W-1:3]] : 1'b0;
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            active_q <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            row_q    <= '0;
            starve_q <= '0;
            en_q     <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            row_q    <= row_d;
            starve_q <= starve_d;
            en_q     <= en_d;
            ovr_q    <= ovr_d;
        end
    end

endmodule

// File: tb/tb_snake_body_scheduler.sv
// Bench for snake_body_scheduler: raster-line stimulus with a pixel
// scoreboard plus per-line scan statistics.
module tb_snake_body_scheduler;

    logic       clock_25 = 1'b0;
    logic       reset;
    logic [9:0] X, Y;
    logic [3:0] snake_length;
    logic       game_req, game_req2;

    logic       seg_rd, game_gnt, en_snake_body, scan_busy, scan_overrun;
    logic [3:0] seg_addr;
    logic [6:0] seg_x, seg_y;

    logic       seg_rd2, game_gnt2, en2, busy2, ovr2;
    logic [3:0] seg_addr2;
    logic [6:0] seg_x2, seg_y2;

    logic [6:0] mem_x [16];
    logic [6:0] mem_y [16];

    typedef struct {
        int   x;
        int   y;
        logic e;
    } pix_t;

    pix_t        sb[$];
    logic [79:0] exp_mask;
    int          checks = 0;
    int          failures = 0;

    int busy_cnt, rd_cnt, first_rd_x, gnt_cnt, both_cnt;
    int rd_cnt2, en2_ones;
    logic [3:0] first_rd_addr;
    int rd_xs[$];

    always #20 clock_25 = ~clock_25;

    always @(posedge clock_25) begin
        if (seg_rd) begin
            seg_x <= mem_x[seg_addr];
            seg_y <= mem_y[seg_addr];
        end
        if (seg_rd2) begin
            seg_x2 <= mem_x[seg_addr2];
            seg_y2 <= mem_y[seg_addr2];
        end
    end

    snake_body_scheduler dut (
        .clock_25     (clock_25),
        .reset        (reset),
        .X            (X),
        .Y            (Y),
        .snake_length (snake_length),
        .seg_rd       (seg_rd),
        .seg_addr     (seg_addr),
        .seg_x        (seg_x),
        .seg_y        (seg_y),
        .game_req     (game_req),
        .game_gnt     (game_gnt),
        .en_snake_body(en_snake_body),
        .scan_busy    (scan_busy),
        .scan_overrun (scan_overrun)
    );

    snake_body_scheduler #(.STARVE(1000)) dut2 (
        .clock_25     (clock_25),
        .reset        (reset),
        .X            (X),
        .Y            (Y),
        .snake_length (snake_length),
        .seg_rd       (seg_rd2),
        .seg_addr     (seg_addr2),
        .seg_x        (seg_x2),
        .seg_y        (seg_y2),
        .game_req     (game_req2),
        .game_gnt     (game_gnt2),
        .en_snake_body(en2),
        .scan_busy    (busy2),
        .scan_overrun (ovr2)
    );

    function automatic bit is_trig(input int y);
        int nl;
        nl = (y == 524) ? 0 : y + 1;
        return (nl < 480) && (nl % 8 == 0);
    endfunction

    task automatic clear_stats();
        busy_cnt   = 0;
        rd_cnt     = 0;
        first_rd_x = -1;
        gnt_cnt    = 0;
        both_cnt   = 0;
        rd_cnt2    = 0;
        en2_ones   = 0;
        rd_xs.delete();
    endtask

    task automatic step(input int x, input int y);
        pix_t p;
        @(negedge clock_25);
        if (sb.size() > 0) begin
            p = sb.pop_front();
            checks++;
            if (en_snake_body !== p.e) begin
                failures++;
                $display("FAIL en_snake_body x=%0d y=%0d got=%b exp=%b",
                         p.x, p.y, en_snake_body, p.e);
            end
        end
        en2_ones += int'(en2);
        X = 10'(x);
        Y = 10'(y);
        p.x = x;
        p.y = y;
        p.e = (x < 640 && y < 480) ? exp_mask[x / 8] : 1'b0;
        sb.push_back(p);
        #1;
        busy_cnt += int'(scan_busy);
        gnt_cnt  += int'(game_gnt);
        if (seg_rd && game_gnt) both_cnt++;
        if (seg_rd) begin
            rd_cnt++;
            rd_xs.push_back(x);
            if (first_rd_x < 0) begin
                first_rd_x    = x;
                first_rd_addr = seg_addr;
            end
        end
        if (seg_rd2) rd_cnt2++;
    endtask

    task automatic run_line(input int y, input logic [79:0] nxt);
        clear_stats();
        for (int x = 0; x < 800; x++) step(x, y);
        if (is_trig(y)) exp_mask = nxt;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic set_seg(input int i, input int sx, input int sy);
        mem_x[i] = 7'(sx);
        mem_y[i] = 7'(sy);
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        X            = '0;
        Y            = '0;
        snake_length = '0;
        game_req     = 1'b1;
        game_req2    = 1'b0;
        exp_mask     = '0;
        for (int i = 0; i < 16; i++) set_seg(i, 127, 127);
        repeat (3) @(negedge clock_25);
        chk("reset seg_rd", int'(seg_rd), 0);
        chk("reset seg_addr", int'(seg_addr), 0);
        chk("reset scan_busy", int'(scan_busy), 0);
        chk("reset scan_overrun", int'(scan_overrun), 0);
        chk("reset en", int'(en_snake_body), 0);
        chk("reset game_gnt", int'(game_gnt), 1);
        reset    = 1'b1;
        game_req = 1'b0;
    endtask

    task automatic test_single_segment();
        logic [79:0] m;
        m = '0;
        m[10] = 1'b1;
        set_seg(0, 10, 3);
        snake_length = 4'd1;
        run_line(22, '0);
        run_line(23, m);
        chk("t1 first_rd_x", first_rd_x, 642);
        chk("t1 first_rd_addr", int'(first_rd_addr), 0);
        chk("t1 rd_cnt", rd_cnt, 1);
        chk("t1 busy_cnt", busy_cnt, 3);
        for (int y = 24; y < 31; y++) run_line(y, '0);
        run_line(31, '0);
        run_line(32, '0);
        chk("t1 overrun", int'(scan_overrun), 0);
    endtask

    task automatic test_duplicates();
        logic [79:0] m;
        m = '0;
        m[5]  = 1'b1;
        m[79] = 1'b1;
        set_seg(0, 5, 3);
        set_seg(1, 5, 3);
        set_seg(2, 79, 3);
        set_seg(3, 100, 3);
        snake_length = 4'd4;
        run_line(23, m);
        chk("t2 busy_cnt", busy_cnt, 9);
        chk("t2 rd_cnt", rd_cnt, 4);
        run_line(24, '0);
        chk("t2 overrun", int'(scan_overrun), 0);
        run_line(31, '0);
    endtask

    task automatic test_starvation();
        logic [79:0] m;
        m = '0;
        m[5]  = 1'b1;
        m[79] = 1'b1;
        game_req = 1'b1;
        run_line(23, m);
        game_req = 1'b0;
        chk("t3 first_rd_x", first_rd_x, 657);
        chk("t3 rd_cnt", rd_cnt, 4);
        chk("t3 gnt_cnt", gnt_cnt, 796);
        chk("t3 rd_and_gnt", both_cnt, 0);
        chk("t3 busy_cnt", busy_cnt, 69);
        for (int i = 1; i < rd_xs.size(); i++)
            chk("t3 rd_gap", rd_xs[i] - rd_xs[i-1], 17);
        run_line(24, '0);
        chk("t3 overrun", int'(scan_overrun), 0);
    endtask

    task automatic test_len_zero();
        set_seg(0, 20, 4);
        snake_length = 4'd0;
        run_line(31, '0);
        chk("t4 rd_cnt", rd_cnt, 0);
        chk("t4 busy_cnt", busy_cnt, 1);
        run_line(32, '0);
        chk("t4 overrun", int'(scan_overrun), 0);
    endtask

    task automatic test_abort();
        logic [79:0] m;
        m = '0;
        m[5]  = 1'b1;
        m[79] = 1'b1;
        set_seg(0, 20, 4);
        set_seg(1, 5, 3);
        set_seg(2, 79, 3);
        set_seg(3, 100, 3);
        snake_length = 4'd4;
        chk("t5 ovr2 before", int'(ovr2), 0);
        game_req2 = 1'b1;
        run_line(23, m);
        chk("t5 rd_cnt2", rd_cnt2, 0);
        run_line(24, '0);
        game_req2 = 1'b0;
        chk("t5 ovr2 set", int'(ovr2), 1);
        chk("t5 en2 blank", en2_ones, 0);
        m = '0;
        m[20] = 1'b1;
        run_line(31, m);
        run_line(32, '0);
        chk("t5 en2 good row", en2_ones, 8);
        chk("t5 ovr2 sticky", int'(ovr2), 1);
        chk("t5 dut overrun", int'(scan_overrun), 0);
    endtask

    task automatic test_reset_mid_scan();
        logic [79:0] m;
        set_seg(0, 20, 4);
        snake_length = 4'd1;
        clear_stats();
        for (int x = 0; x <= 643; x++) step(x, 23);
        chk("t6 busy before", int'(scan_busy), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6 busy async", int'(scan_busy), 0);
        chk("t6 seg_rd async", int'(seg_rd), 0);
        chk("t6 ovr2 async", int'(ovr2), 0);
        chk("t6 en async", int'(en_snake_body), 0);
        sb.delete();
        exp_mask = '0;
        @(negedge clock_25);
        reset = 1'b1;
        run_line(24, '0);
        m = '0;
        m[20] = 1'b1;
        run_line(31, m);
        chk("t6 rd_cnt", rd_cnt, 1);
        chk("t6 busy_cnt", busy_cnt, 3);
        run_line(32, '0);
        chk("t6 overrun", int'(scan_overrun), 0);
    endtask

    initial begin
        test_reset();
        test_single_segment();
        test_duplicates();
        test_starvation();
        test_len_zero();
        test_abort();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
